regfile_write_arbiter: RTL

Shares the single synchronous write port of the 32x32 register file between several write requesters, such as pipeline writeback, a multi-cycle mul/div unit and a debug port. It uses round-robin arbitration with an optional absolute-priority override for requester 0. It optionally sequences a post-reset sweep that writes a known value into x1..x31, because register contents are not reset by hardware. It sits between the requesters and the register file write inputs (we, A3, wd3).

---
 rtl/regfile_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: round-robin with requester-0 priority override.
// Optional post-reset sweep of x1..x31 under RF_INIT_CLEAR_EN.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] INIT_VAL = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 prio0_en,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic                 init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef RF_INIT_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;
  logic [4:0] cnt;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd2
  } state_t;
`endif

  state_t state, state_nxt;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_idx;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] k;
  logic          rr_hit;
  logic          prio_win;
  logic          gnt;
  logic [4:0]    g_addr;
  logic [XLEN-1:0] g_data;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    k      = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = PW'((int'(rr_ptr) + i) % NREQ);
      if (!rr_hit && req_valid[k]) begin
        rr_hit = 1'b1;
        rr_idx = k;
      end
    end
  end

  // Grant selection and granted-requester payload mux
  always_comb begin
    prio_win = prio0_en & req_valid[0];
    gnt      = prio_win | rr_hit;
    gnt_idx  = prio_win ? '0 : rr_idx;
    ptr_nxt  = (rr_idx == PW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
    g_addr   = req_addr[int'(gnt_idx)*5 +: 5];
    g_data   = req_data[int'(gnt_idx)*XLEN +: XLEN];
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_a3     = '0;
    rf_wd3    = '0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
`ifdef RF_INIT_CLEAR_EN
        state_nxt = INIT;
`else
        state_nxt = RUN;
`endif
      end
`ifdef RF_INIT_CLEAR_EN
      INIT: begin
        rf_we  = 1'b1;
        rf_a3  = cnt;
        rf_wd3 = INIT_VAL;
        if (cnt == 5'd31) state_nxt = RUN;
      end
`endif
      RUN: begin
        if (gnt) begin
          req_ready[gnt_idx] = 1'b1;
          rf_a3  = g_addr;
          rf_wd3 = g_data;
          rf_we  = (g_addr != 5'd0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and init_done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RUN);
      if (state == RUN && gnt && !prio_win) rr_ptr <= ptr_nxt;
    end
  end

`ifdef RF_INIT_CLEAR_EN
  // Sweep counter: loaded with 1 on INIT entry, steps once per sweep write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= 5'd1;
    end else if (state == INIT) begin
      cnt <= cnt + 5'd1;
    end
  end
`endif

endmodule
